// File: rtl/count_seq_ctrl_pkg.sv
// Shared types and defaults for the count_seq_ctrl run controller.
package count_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } csc_state_e;

    localparam int CSC_WIDTH_DEF = 4;

endpackage

// File: rtl/count_seq_ctrl_up_counter.sv
// WIDTH-bit up-counter with synchronous clear (dominant over enable).
module up_counter_en #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr)
            q_d = '0;
        else if (en)
            q_d = q_q + WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/count_seq_ctrl.sv
// Run controller owning an up-counter: start/clear, run, pause, abort, done pulse.
// Define COUNT_SEQ_CTRL_AUTORELOAD_EN for periodic (auto-reloading) runs.
module count_seq_ctrl
    import count_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = CSC_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    csc_state_e       state_q, state_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             done_q, done_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic [WIDTH-1:0] cnt_q;

    always_comb begin
        state_d = state_q;
        limit_d = limit_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    limit_d = limit;
                    cnt_clr = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN, PAUSE: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end else if (pause) begin
                    state_d = PAUSE;
                end else begin
                    // Leaving PAUSE steps in the same cycle, so no dead cycle.
                    state_d = RUN;
                    if (cnt_q == limit_q) begin
                        done_d = 1'b1;
`ifdef COUNT_SEQ_CTRL_AUTORELOAD_EN
                        cnt_clr = 1'b1;
`else
                        state_d = DONE;
`endif
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            limit_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            limit_q <= limit_d;
            done_q  <= done_d;
        end
    end

    up_counter_en #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .q     (cnt_q)
    );

    assign q    = cnt_q;
    assign busy = (state_q == RUN) || (state_q == PAUSE);
    assign done = done_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl; single-shot or autoreload per COUNT_SEQ_CTRL_AUTORELOAD_EN.
module tb_count_seq_ctrl;
    import count_seq_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] limit;
    logic       pause;
    logic       abort;
    logic [3:0] q;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    count_seq_ctrl #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .limit (limit),
        .pause (pause),
        .abort (abort),
        .q     (q),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] eq, input logic eb, input logic ed);
        chk({tag, ".q"},    32'(q),    32'(eq));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; limit = 4'd5; pause = 1'b0; abort = 1'b0;

        // Reset dominates a pending start.
        for (int i = 0; i < 2; i++) begin
            step();
            chk_out("reset", 4'd0, 1'b0, 1'b0);
            chk("reset.state", 32'(dut.state_q), 32'(IDLE));
        end
        reset = 1'b0; start = 1'b0;
        step();
        chk_out("idle", 4'd0, 1'b0, 1'b0);

        // Abort at q=7 of a limit-15 run.
        start = 1'b1; limit = 4'd15;
        step();
        start = 1'b0;
        chk_out("ab.start", 4'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) step();
        chk_out("ab.q7", 4'd7, 1'b1, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_out("ab.stop", 4'd0, 1'b0, 1'b0);
        chk("ab.state", 32'(dut.state_q), 32'(IDLE));
        step();
        chk_out("ab.after", 4'd0, 1'b0, 1'b0);

`ifdef COUNT_SEQ_CTRL_AUTORELOAD_EN
        // Periodic run, limit=2: q 0,1,2,0,... with done on each reload.
        start = 1'b1; limit = 4'd2;
        step();
        start = 1'b0;
        chk_out("ar.s0", 4'd0, 1'b1, 1'b0);
        for (int p = 0; p < 2; p++) begin
            step(); chk_out("ar.q1", 4'd1, 1'b1, 1'b0);
            step(); chk_out("ar.q2", 4'd2, 1'b1, 1'b0);
            step(); chk_out("ar.wrap", 4'd0, 1'b1, 1'b1);
        end
        step(); chk_out("ar.q1b", 4'd1, 1'b1, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_out("ar.abort", 4'd0, 1'b0, 1'b0);
        chk("ar.state", 32'(dut.state_q), 32'(IDLE));
`else
        // limit=5 single shot; limit input changes mid-run must be ignored.
        start = 1'b1; limit = 4'd5;
        step();
        start = 1'b0; limit = 4'd1;
        chk_out("l5.s0", 4'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk_out("l5.run", 4'(k), 1'b1, 1'b0);
        end
        step();
        chk_out("l5.done", 4'd5, 1'b0, 1'b1);
        step();
        chk_out("l5.idle", 4'd5, 1'b0, 1'b0);
        chk("l5.state", 32'(dut.state_q), 32'(IDLE));

        // limit=3 with two pause cycles at q=1.
        start = 1'b1; limit = 4'd3;
        step();
        start = 1'b0;
        chk_out("ps.s0", 4'd0, 1'b1, 1'b0);
        step(); chk_out("ps.q1", 4'd1, 1'b1, 1'b0);
        pause = 1'b1;
        step(); chk_out("ps.hold1", 4'd1, 1'b1, 1'b0);
        step(); chk_out("ps.hold2", 4'd1, 1'b1, 1'b0);
        pause = 1'b0;
        step(); chk_out("ps.q2", 4'd2, 1'b1, 1'b0);
        step(); chk_out("ps.q3", 4'd3, 1'b1, 1'b0);
        step(); chk_out("ps.done", 4'd3, 1'b0, 1'b1);
        step(); chk_out("ps.idle", 4'd3, 1'b0, 1'b0);

        // limit=0, restart in DONE with limit=2, start while busy ignored.
        start = 1'b1; limit = 4'd0;
        step();
        chk_out("l0.s0", 4'd0, 1'b1, 1'b0);
        limit = 4'd2;
        step();
        chk_out("l0.done", 4'd0, 1'b0, 1'b1);
        step();
        start = 1'b0;
        chk_out("bb.s0", 4'd0, 1'b1, 1'b0);
        step(); chk_out("bb.q1", 4'd1, 1'b1, 1'b0);
        start = 1'b1; limit = 4'd0;
        step();
        start = 1'b0;
        chk_out("bb.q2", 4'd2, 1'b1, 1'b0);
        step(); chk_out("bb.done", 4'd2, 1'b0, 1'b1);
        step(); chk_out("bb.idle", 4'd2, 1'b0, 1'b0);
        chk("bb.state", 32'(dut.state_q), 32'(IDLE));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
